// File: rtl/avr_spi_slave.sv
// SPI slave for the AVR link, fully oversampled in the fclk domain.
// Captures the command byte with CS high, turns data bytes into write strobes and streams read-back bytes.
module avr_spi_slave #(
  parameter logic [7:0] SD_CMD0 = 8'h57,
  parameter logic [7:0] SD_CMD1 = 8'h5f
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       spics_n,
  input  logic       spick,
  input  logic       spido,
  output logic       spidi,
  output logic [7:0] cmd,
  output logic       sd_sel,
  output logic       wr_stb,
  output logic [7:0] wr_data,
  output logic [7:0] wr_idx,
  output logic       rd_stb,
  input  logic [7:0] rd_data,
  output logic       frag_err
);

  logic       cs_s1_q, cs_s2_q, cs_s3_q;
  logic       ck_s1_q, ck_s2_q, ck_s3_q;
  logic       do_s1_q, do_s2_q;

  logic       armed_q, armed_d;
  logic [7:0] cmd_q, cmd_d;
  logic [6:0] rx_q, rx_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] tx_q, tx_d;
  logic       spidi_q, spidi_d;
  logic       wr_stb_q, wr_stb_d;
  logic       rd_stb_q, rd_stb_d;
  logic       frag_q, frag_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] wr_idx_q, wr_idx_d;

  logic       ck_rise, ck_fall, cs_rise, cs_fall;
  logic       sd_cmd, data_on, bit_in;
  logic [2:0] cnt_base;

  assign ck_rise = ck_s2_q & ~ck_s3_q;
  assign ck_fall = ~ck_s2_q & ck_s3_q;
  assign cs_rise = cs_s2_q & ~cs_s3_q;
  assign cs_fall = ~cs_s2_q & cs_s3_q;
  assign bit_in  = do_s2_q;
  assign sd_cmd  = (cmd_q == SD_CMD0) || (cmd_q == SD_CMD1);
  // Data path only runs once a clean CS high has been seen since reset.
  assign data_on = armed_q & ~sd_cmd;

  always_comb begin
    armed_d   = armed_q;
    cmd_d     = cmd_q;
    rx_d      = rx_q;
    bitcnt_d  = bitcnt_q;
    tx_d      = tx_q;
    spidi_d   = spidi_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    frag_d    = 1'b0;
    wr_data_d = wr_data_q;
    wr_idx_d  = wr_idx_q;
    cnt_base  = bitcnt_q;

    if (wr_stb_q) begin
      wr_idx_d = wr_idx_q + 8'd1;
    end

    // The fall closing a byte (bitcnt back at 0) keeps the prefetched MSB on spidi.
    if (rd_stb_q) begin
      tx_d    = rd_data[6:0];
      spidi_d = rd_data[7];
    end else if (ck_fall && !cs_s2_q && data_on && bitcnt_q != 3'd0) begin
      spidi_d = tx_q[6];
      tx_d    = {tx_q[5:0], 1'b1};
    end

    if (cs_fall && data_on) begin
      cnt_base = 3'd0;
      bitcnt_d = 3'd0;
      wr_idx_d = 8'd0;
      rd_stb_d = 1'b1;
    end

    if (ck_rise) begin
      if (cs_s2_q) begin
        cmd_d = {cmd_q[6:0], bit_in};
      end else if (data_on) begin
        rx_d     = {rx_q[5:0], bit_in};
        bitcnt_d = cnt_base + 3'd1;
        if (cnt_base == 3'd7) begin
          wr_data_d = {rx_q, bit_in};
          wr_stb_d  = 1'b1;
          rd_stb_d  = 1'b1;
        end
      end
    end

    if (cs_rise) begin
      spidi_d = 1'b1;
      armed_d = 1'b1;
      if (data_on && bitcnt_q != 3'd0) begin
        frag_d = 1'b1;
      end
      if (data_on) begin
        bitcnt_d = 3'd0;
      end
    end
  end

  // CS synchronizer resets low so a frame in progress at reset is never seen as a fresh cs_fall.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      cs_s3_q   <= 1'b0;
      ck_s1_q   <= 1'b0;
      ck_s2_q   <= 1'b0;
      ck_s3_q   <= 1'b0;
      do_s1_q   <= 1'b0;
      do_s2_q   <= 1'b0;
      armed_q   <= 1'b0;
      cmd_q     <= 8'h00;
      rx_q      <= 7'h00;
      bitcnt_q  <= 3'd0;
      tx_q      <= 7'h7f;
      spidi_q   <= 1'b1;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      frag_q    <= 1'b0;
      wr_data_q <= 8'h00;
      wr_idx_q  <= 8'h00;
    end else begin
      cs_s1_q   <= spics_n;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      ck_s1_q   <= spick;
      ck_s2_q   <= ck_s1_q;
      ck_s3_q   <= ck_s2_q;
      do_s1_q   <= spido;
      do_s2_q   <= do_s1_q;
      armed_q   <= armed_d;
      cmd_q     <= cmd_d;
      rx_q      <= rx_d;
      bitcnt_q  <= bitcnt_d;
      tx_q      <= tx_d;
      spidi_q   <= spidi_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      frag_q    <= frag_d;
      wr_data_q <= wr_data_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  assign spidi    = spidi_q;
  assign cmd      = cmd_q;
  assign sd_sel   = sd_cmd & ~spics_n;
  assign wr_stb   = wr_stb_q;
  assign wr_data  = wr_data_q;
  assign wr_idx   = wr_idx_q;
  assign rd_stb   = rd_stb_q;
  assign frag_err = frag_q;

endmodule

// File: tb/tb_avr_spi_slave.sv
// Bench for avr_spi_slave: SPI master tasks, pulse monitor and a frame-level reference model.
module tb_avr_spi_slave;

  logic       fclk = 1'b0;
  logic       rst;
  logic       spics_n, spick, spido;
  logic       spidi;
  logic [7:0] cmd;
  logic       sd_sel;
  logic       wr_stb;
  logic [7:0] wr_data, wr_idx;
  logic       rd_stb;
  logic [7:0] rd_data;
  logic       frag_err;

  always #5 fclk = ~fclk;

  avr_spi_slave dut (
    .fclk(fclk), .rst(rst), .spics_n(spics_n), .spick(spick), .spido(spido),
    .spidi(spidi), .cmd(cmd), .sd_sel(sd_sel), .wr_stb(wr_stb), .wr_data(wr_data),
    .wr_idx(wr_idx), .rd_stb(rd_stb), .rd_data(rd_data), .frag_err(frag_err)
  );

  // Read-back source: one table entry per rd_stb the DUT issues.
  logic [7:0] rd_tbl [0:255];
  int         rd_cnt = 0;
  assign rd_data = rd_tbl[rd_cnt[7:0]];
  always @(posedge fclk) if (rd_stb) rd_cnt <= rd_cnt + 1;

  // Pulse monitor, sampled on the falling edge.
  logic [15:0] wr_log [0:1023];
  int          wr_n = 0, rd_seen = 0, frag_seen = 0;
  always @(negedge fclk) begin
    if (wr_stb) begin
      wr_log[wr_n[9:0]] <= {wr_data, wr_idx};
      wr_n <= wr_n + 1;
    end
    if (rd_stb) rd_seen <= rd_seen + 1;
    if (frag_err) frag_seen <= frag_seen + 1;
  end

  int          n_checks = 0, n_fail = 0;
  int          h = 5;
  int          rd_model = 0;
  logic [7:0]  m_cmd = 8'h00;
  logic [7:0]  tx_bytes [0:7];
  logic [15:0] miso_seq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic miso);
    spido = b;
    wait_cyc(h);
    miso  = spidi;
    spick = 1'b1;
    wait_cyc(h);
    spick = 1'b0;
  endtask

  // Shift n bits (MSB first) with CS high; the model keeps the last 8.
  task automatic send_cmd(input logic [15:0] bits, input int n);
    logic m;
    int   w0;
    w0 = wr_n;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(bits[i], m);
      m_cmd = {m_cmd[6:0], bits[i]};
    end
    wait_cyc(h);
    check_eq("cmd", cmd, m_cmd);
    check_eq("cmd_no_wr", wr_n - w0, 0);
    $display("cmd shift: %0d bits -> cmd=%02h", n, cmd);
  endtask

  // One CS-low frame of nbits bits taken from tx_bytes.
  task automatic data_frame(input int nbits);
    logic       sd, m, eb;
    logic [7:0] txb, exp_byte;
    int         w0, r0, f0, base, nfull, idx;
    sd    = (m_cmd == 8'h57) || (m_cmd == 8'h5f);
    w0    = wr_n; r0 = rd_seen; f0 = frag_seen; base = rd_model;
    nfull = nbits / 8;
    spics_n = 1'b0;
    #1;
    check_eq("sd_sel_cs_low", sd_sel, sd);
    wait_cyc(h);
    for (int i = 0; i < nbits; i++) begin
      txb = tx_bytes[i / 8];
      spi_bit(txb[7 - (i % 8)], m);
      miso_seq = {miso_seq[14:0], m};
      if (!sd) begin
        idx      = (base + i / 8) % 256;
        exp_byte = rd_tbl[idx];
        eb       = exp_byte[7 - (i % 8)];
        check_eq("miso_bit", m, eb);
      end
    end
    wait_cyc(h);
    spics_n = 1'b1;
    wait_cyc(8);
    check_eq("spidi_idle", spidi, 1);
    check_eq("sd_sel_cs_high", sd_sel, 0);
    if (sd) begin
      check_eq("sd_wr_cnt", wr_n - w0, 0);
      check_eq("sd_rd_cnt", rd_seen - r0, 0);
      check_eq("sd_frag", frag_seen - f0, 0);
    end else begin
      check_eq("wr_cnt", wr_n - w0, nfull);
      for (int k = 0; k < nfull && w0 + k < wr_n; k++)
        check_eq("wr_data_idx", wr_log[(w0 + k) % 1024], {tx_bytes[k], k[7:0]});
      check_eq("rd_cnt", rd_seen - r0, nfull + 1);
      check_eq("frag_cnt", frag_seen - f0, (nbits % 8) != 0);
      rd_model = rd_model + nfull + 1;
    end
    $display("frame: cmd=%02h bits=%0d sd=%0d writes=%0d reads=%0d frags=%0d",
             m_cmd, nbits, sd, wr_n - w0, rd_seen - r0, frag_seen - f0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_spidi"}, spidi, 1);
    check_eq({tag, "_cmd"}, cmd, 8'h00);
    check_eq({tag, "_wr_data"}, wr_data, 8'h00);
    check_eq({tag, "_wr_idx"}, wr_idx, 8'h00);
    check_eq({tag, "_strobes"}, {wr_stb, rd_stb, frag_err}, 3'b000);
    check_eq({tag, "_sd_sel"}, sd_sel, 0);
  endtask

  initial begin
    logic m;
    int   w0, r0, f0, nb;
    logic [15:0] cb;
    for (int i = 0; i < 256; i++) rd_tbl[i] = 8'($urandom);
    rst = 1'b1; spics_n = 1'b1; spick = 1'b0; spido = 1'b0;
    wait_cyc(3);
    check_reset_outputs("por");
    rst = 1'b0;
    wait_cyc(6);

    send_cmd(16'h00f3, 8);
    check_eq("sd_sel_f3", sd_sel, 0);

    tx_bytes[0] = 8'h9c; tx_bytes[1] = 8'h21;
    rd_tbl[rd_model % 256] = 8'ha5;
    rd_tbl[(rd_model + 1) % 256] = 8'h3c;
    data_frame(16);
    check_eq("miso_seq_a53c", miso_seq, 16'ha53c);

    send_cmd(16'h0044, 8);
    tx_bytes[0] = 8'h41; tx_bytes[1] = 8'h42; tx_bytes[2] = 8'h43;
    data_frame(24);

    tx_bytes[0] = 8'hb7;
    data_frame(5);

    send_cmd(16'h0057, 8);
    data_frame(8);

    // Reset in the middle of a frame, then finish the frame blindly.
    send_cmd(16'h0044, 8);
    spics_n = 1'b0;
    wait_cyc(h);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    rd_model = rd_model + 1;
    w0 = wr_n; f0 = frag_seen;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    m_cmd = 8'h00;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);
    r0 = rd_seen;
    for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
    wait_cyc(h);
    spics_n = 1'b1;
    wait_cyc(8);
    check_eq("rst_tail_wr", wr_n - w0, 0);
    check_eq("rst_tail_rd", rd_seen - r0, 0);
    check_eq("rst_tail_frag", frag_seen - f0, 0);
    check_eq("rst_tail_spidi", spidi, 1);
    $display("reset mid-frame: tail writes=%0d frags=%0d", wr_n - w0, frag_seen - f0);
    send_cmd(16'h0040, 8);
    tx_bytes[0] = 8'h12;
    data_frame(8);

    for (int t = 0; t < 16; t++) begin
      h  = $urandom_range(4, 7);
      nb = $urandom_range(8, 12);
      cb = 16'($urandom);
      send_cmd(cb, nb);
      if (m_cmd == 8'h57 || m_cmd == 8'h5f) begin
        if (t % 4 != 0) send_cmd(16'h00a6, 8);
      end
      for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
      data_frame($urandom_range(0, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avr_spi_slave.md
# avr_spi_slave

Fclk-domain SPI slave for the AVR-to-FPGA link in the flasher FPGA. It oversamples `spics_n`/`spick`/`spido` with `fclk` and captures the command byte shifted while CS is high. It turns every complete data byte shifted while CS is low into a one-cycle register-write strobe, and streams read-back bytes MSB-first on `spidi`. It sits directly upstream of the flash/screen register file, replacing the spick-clocked shift logic, and flags SD-card pass-through frames for the top-level mux.

## Interface
Parameters:
- `SD_CMD0`, 8'h57, command selecting SD pass-through (CS asserted to card)
- `SD_CMD1`, 8'h5f, command selecting SD pass-through (card CS not asserted)

Ports:
- `fclk`  in  1  system clock (28 MHz); only clock
- `rst`  in  1  asynchronous, active-high reset
- `spics_n`  in  1  AVR chip select, asynchronous to `fclk`
- `spick`  in  1  AVR SPI clock (mode 0), asynchronous
- `spido`  in  1  AVR MOSI, asynchronous
- `spidi`  out  1  MISO data from FPGA, registered
- `cmd`  out  8  current command byte
- `sd_sel`  out  1  `cmd` is `SD_CMD0`/`SD_CMD1` and raw `spics_n` low (combinational)
- `wr_stb`  out  1  one-cycle pulse: `wr_data` complete for command `cmd`
- `wr_data`  out  8  received data byte
- `wr_idx`  out  8  byte index within frame (0 = first), wraps 255->0
- `rd_stb`  out  1  one-cycle pulse: supply byte for `cmd`
- `rd_data`  in  8  read-back byte, sampled on the `fclk` edge ending `rd_stb`
- `frag_err`  out  1  one-cycle pulse: frame ended with partial byte

## Operation
- Synchronizers: `spics_n`, `spick`, `spido` each pass through 2 flops (s1, s2) plus history flop s3. `ck_rise` = s2&~s3 on spick. `ck_fall` = ~s2&s3. `cs_fall`/`cs_rise` are the same on spics_n. `spido` s2 is the sampled bit.
- A `ck_rise` is attributed to the frame by the synchronized `spics_n` (s2) in the same cycle.
- CS high, `ck_rise`: `cmd <= {cmd[6:0], bit}`. No framing; the last 8 bits win.
- `cs_fall`, when not `sd_sel`:
  - `bitcnt`=0, `wr_idx`=0.
  - Issue `rd_stb`.
  - Next cycle: `tx <= rd_data`, `spidi <= rd_data[7]`.
- CS low, `ck_rise`:
  - `rx <= {rx[6:0], bit}`, `bitcnt++` (3-bit).
  - On the 8th bit (`bitcnt` was 7): `wr_data <= {rx[6:0], bit}` and `wr_stb`=1 for one cycle. On the following cycle `wr_idx` increments.
  - Also issue `rd_stb` together with `wr_stb` to prefetch the next tx byte, loaded the cycle after.
- CS low, `ck_fall`: `tx <= {tx[6:0],1}`, `spidi <= tx[6]`. After 8 falls without a reload, `spidi`=1.
- `cs_rise` with `bitcnt`!=0: partial byte discarded, `frag_err` pulse, no `wr_stb`. With `bitcnt`=0: no action. In both cases `spidi <= 1`.
- `sd_sel` frames: no `wr_stb`/`rd_stb`/`frag_err`, and `bitcnt` frozen. The top muxes `sddi`.
- Reset mid-frame: all state returns to reset values. The remainder of the frame is treated as a frame starting from unknown bit position; a new frame resumes normal operation only after `cs_rise` followed by `cs_fall`.

## Timing
- Reset values: `spidi`=1, `cmd`=8'h00, `wr_data`=8'h00, `wr_idx`=0, `wr_stb`=`rd_stb`=`frag_err`=0, `tx`=8'hff, `bitcnt`=0; `sd_sel`=0 (follows `cmd`).
- Latency from the first `fclk` edge sampling a new pin level to the action register update: 3 edges (s1, s2, update).
  - `wr_stb` is high during the cycle after that third edge.
- `spidi` change after `ck_fall`: 3 `fclk` edges from pin.
- Constraint on the master: `spick` high and low phases ≥ 4 `fclk` periods (SPI ≤ fclk/8 = 3.5 MHz). CS setup/hold to `spick` ≥ 4 `fclk`.
- `wr_stb` and `rd_stb` never assert on the same cycle as `cs_rise`. `cs_fall` and `ck_rise` in the same cycle: both are processed (reset counters, then count the bit as bit 0).
- `rd_data` must be valid combinationally while `rd_stb`=1.

## Test plan
- CS high, shift 0xF3 (8 rising edges) -> `cmd`=8'hF3, `sd_sel`=0, no `wr_stb`.
- `cmd`=0x44; CS low, shift 0x41,0x42,0x43; CS high -> three `wr_stb` pulses with `wr_data`/`wr_idx` = 41/0, 42/1, 43/2; `frag_err`=0.
- `cmd`=0xF3, `rd_data` returns 0xA5 then 0x3C; 16 clocks in frame -> `spidi` sequence sampled at spick rises: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; `rd_stb` 2 pulses (at `cs_fall` and after byte 0), plus one after byte 1.
- CS low, 5 bits then CS high -> `frag_err` single pulse, no `wr_stb`, `spidi`=1 after `cs_rise`.
- `cmd`=0x57, CS low -> `sd_sel`=1 within 0 cycles of raw CS; 8 clocks -> no `wr_stb`/`rd_stb`; CS high -> `sd_sel`=0.
- Assert `rst` after 3 data bits mid-frame -> all outputs reset values immediately; next full frame with `cmd`=0x40 and data 0x12 -> `wr_stb` with `wr_data`=8'h12, `wr_idx`=0.
